cmd_frame_receiver: RTL and testbench

- Parametrised successor of the fixed 5-bit serial command register.
- Deserialises framed commands from a one-bit serial line: configurable header pattern, command width, inter-bit gap timeout, and a valid/ack output handshake.
- Reports header, overflow and timeout errors.
- Sits between the serial pad interface and the command decoder. All state is on the rising clock edge; there is no negative-edge stage.

---
 rtl/cmd_frame_receiver.sv | 147 ++++++++++++++
 tb/tb_cmd_frame_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : cmd_frame_receiver
// Description : Serial framed-command deserialiser with header check, gap
//               timeout and valid/ack output slot. Optional trailing
//               even-parity bit enabled by CMDFRAME_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_receiver #(
    parameter int               CMD_W       = 2,
    parameter int               HDR_W       = 3,
    parameter logic [HDR_W-1:0] HDR_PATTERN = 3'b101,
    parameter int               GAP_MAX     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    input  logic             receive,
    output logic [CMD_W-1:0] command,
    output logic             cmd_valid,
    input  logic             cmd_ack,
    output logic             busy,
    output logic             empty,
    output logic             err_header,
    output logic             err_overflow,
    output logic             err_timeout
`ifdef CMDFRAME_PARITY_EN
    ,
    output logic             err_parity
`endif
);

`ifdef CMDFRAME_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W = HDR_W + CMD_W + PAR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP_MAX - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic [GAP_W-1:0]   r_gap;

    logic [FRAME_W-1:0] w_frame;
    logic [HDR_W-1:0]   w_hdr;
    logic [CMD_W-1:0]   w_cmd;
    logic               w_slot_free;

    // Completion is judged on the frame including the bit sampled this edge
    assign w_frame     = {r_shreg[FRAME_W-2:0], data};
    assign w_hdr       = w_frame[FRAME_W-1 -: HDR_W];
    assign w_cmd       = w_frame[PAR_W +: CMD_W];
    assign w_slot_free = !cmd_valid || cmd_ack;

`ifdef CMDFRAME_PARITY_EN
    logic w_par_ok;
    assign w_par_ok = ~^w_frame[CMD_W:0];
`endif

    assign busy  = (r_state == S_SHIFT);
    assign empty = (r_state == S_IDLE) && !cmd_valid && (r_shreg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_gap        <= '0;
            command      <= '0;
            cmd_valid    <= 1'b0;
            err_header   <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
`ifdef CMDFRAME_PARITY_EN
            err_parity   <= 1'b0;
`endif
        end else begin
            err_header   <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
`ifdef CMDFRAME_PARITY_EN
            err_parity   <= 1'b0;
`endif
            if (cmd_ack && cmd_valid) begin
                cmd_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (receive) begin
                        r_shreg <= w_frame;
                        r_cnt   <= CNT_W'(1);
                        r_gap   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (receive) begin
                        r_shreg <= w_frame;
                        r_gap   <= '0;
                        if (r_cnt == C_CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            if (w_hdr != HDR_PATTERN) begin
                                err_header <= 1'b1;
`ifdef CMDFRAME_PARITY_EN
                            end else if (!w_par_ok) begin
                                err_parity <= 1'b1;
`endif
                            end else if (w_slot_free) begin
                                command   <= w_cmd;
                                cmd_valid <= 1'b1;
                            end else begin
                                err_overflow <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_gap == C_GAP_LAST) begin
                        // Gap limit reached: abandon the partial frame
                        err_timeout <= 1'b1;
                        r_shreg     <= '0;
                        r_cnt       <= '0;
                        r_gap       <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_frame_receiver
// Description : Directed self-checking bench for cmd_frame_receiver (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_receiver;

    logic       clk;
    logic       rst;
    logic       data;
    logic       receive;
    logic [1:0] command;
    logic       cmd_valid;
    logic       cmd_ack;
    logic       busy;
    logic       empty;
    logic       err_header;
    logic       err_overflow;
    logic       err_timeout;
`ifdef CMDFRAME_PARITY_EN
    logic       err_parity;
`endif

    int         n_assert;
    int         n_fail;
    logic [1:0] exp_q[$];
    logic [1:0] exp_cmd;

    cmd_frame_receiver dut (
        .clk          (clk),
        .rst          (rst),
        .data         (data),
        .receive      (receive),
        .command      (command),
        .cmd_valid    (cmd_valid),
        .cmd_ack      (cmd_ack),
        .busy         (busy),
        .empty        (empty),
        .err_header   (err_header),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout)
`ifdef CMDFRAME_PARITY_EN
        ,
        .err_parity   (err_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_no_err(input string tag);
        chk({tag, "_errs"}, {29'd0, err_header, err_overflow, err_timeout}, 32'd0);
    endtask

    // Five-bit frame, MSB first; optional ack on the edge sampling the last bit
    task automatic send_frame(input logic [4:0] bits, input logic ack_last);
        for (int i = 4; i >= 0; i--) begin
            data    = bits[i];
            receive = 1'b1;
            cmd_ack = (i == 0) ? ack_last : 1'b0;
            tick();
        end
        receive = 1'b0;
        data    = 1'b0;
        cmd_ack = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        data     = 1'b0;
        receive  = 1'b0;
        cmd_ack  = 1'b0;
        tick();
        tick();
        chk("rst_command", command, 2'b00);
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk_no_err("rst");
        rst = 1'b0;

        // Reset mid-frame: two bits in, then async reset without a clock edge
        data = 1'b1; receive = 1'b1; tick();
        data = 1'b0; tick();
        receive = 1'b0;
        chk("midframe_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_empty", empty, 1'b1);
        tick();
        rst = 1'b0;
        send_frame(5'b10110, 1'b0);
        exp_q.push_back(2'b10);
        exp_cmd = exp_q.pop_front();
        chk("load1_valid", cmd_valid, 1'b1);
        chk("load1_cmd", command, exp_cmd);
        chk_no_err("load1");

        // Bad header while slot is full
        send_frame(5'b11101, 1'b0);
        chk("hdr_pulse", err_header, 1'b1);
        chk("hdr_ovf", err_overflow, 1'b0);
        chk("hdr_valid", cmd_valid, 1'b1);
        chk("hdr_cmd", command, 2'b10);
        chk("hdr_busy", busy, 1'b0);
        tick();
        chk("hdr_pulse_end", err_header, 1'b0);

        // Ack clears valid, command holds
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        chk("ack_valid", cmd_valid, 1'b0);
        chk("ack_cmd_hold", command, 2'b10);
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        chk("idle_ack_valid", cmd_valid, 1'b0);

        // Overflow
        send_frame(5'b10101, 1'b0);
        exp_q.push_back(2'b01);
        exp_cmd = exp_q.pop_front();
        chk("load2_valid", cmd_valid, 1'b1);
        chk("load2_cmd", command, exp_cmd);
        send_frame(5'b10111, 1'b0);
        chk("ovf_pulse", err_overflow, 1'b1);
        chk("ovf_hdr", err_header, 1'b0);
        chk("ovf_cmd", command, 2'b01);
        chk("ovf_valid", cmd_valid, 1'b1);
        tick();
        chk("ovf_pulse_end", err_overflow, 1'b0);

        // Ack collides with final bit: new command loads, no overflow
        send_frame(5'b10110, 1'b1);
        exp_q.push_back(2'b10);
        exp_cmd = exp_q.pop_front();
        chk("coll_valid", cmd_valid, 1'b1);
        chk("coll_cmd", command, exp_cmd);
        chk_no_err("coll");

        // Back-to-back frames, each acking the previous command
        send_frame(5'b10101, 1'b1);
        exp_q.push_back(2'b01);
        send_frame(5'b10100, 1'b1);
        exp_q.push_back(2'b00);
        exp_cmd = exp_q.pop_front();
        exp_cmd = exp_q.pop_front();
        chk("b2b_cmd", command, exp_cmd);
        chk("b2b_valid", cmd_valid, 1'b1);
        chk_no_err("b2b");
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        chk("b2b_ack_valid", cmd_valid, 1'b0);

        // Timeout after four low cycles
        data = 1'b1; receive = 1'b1; tick();
        data = 1'b0; tick();
        receive = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("to_early", err_timeout, 1'b0);
            chk("to_busy", busy, 1'b1);
        end
        tick();
        chk("to_pulse", err_timeout, 1'b1);
        chk("to_idle", busy, 1'b0);
        chk("to_empty", empty, 1'b1);
        chk("to_valid", cmd_valid, 1'b0);
        tick();
        chk("to_pulse_end", err_timeout, 1'b0);

        // Three low cycles then the frame resumes and completes
        data = 1'b1; receive = 1'b1; tick();
        data = 1'b0; tick();
        receive = 1'b0;
        tick(); tick(); tick();
        chk("gap3_no_to", err_timeout, 1'b0);
        chk("gap3_busy", busy, 1'b1);
        data = 1'b1; receive = 1'b1; tick();
        data = 1'b1; tick();
        data = 1'b0; tick();
        receive = 1'b0;
        exp_q.push_back(2'b10);
        exp_cmd = exp_q.pop_front();
        chk("gap3_valid", cmd_valid, 1'b1);
        chk("gap3_cmd", command, exp_cmd);
        chk_no_err("gap3");
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
